serial_word_compare: RTL and testbench

- Bit-serial, handshaked counterpart of the parallel 6-bit XOR equality comparator.
- Captures two WIDTH-bit operands and scans them MSB-first, one bit per clock, through a single one-bit XOR compare.
- Reports mismatch, the index of the most significant differing bit and, optionally, magnitude.
- Used where the design trades latency for a single-bit datapath and must tell the consumer *where* two words differ, not only *whether*.

---
 rtl/serial_word_compare.sv | 108 ++++++++++
 tb/tb_serial_word_compare.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_compare.sv
// rtl/serial_word_compare.sv - bit-serial MSB-first word comparator with first-mismatch index.
// Optional macro MAG_COMPARE_EN adds unsigned gt/lt capture at the first mismatch.
module serial_word_compare #(
    parameter  int WIDTH = 6,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             diff,
    output logic [IDX_W-1:0] first_idx,
    output logic             gt,
    output logic             lt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [IDX_W-1:0] cnt;
    logic             m;

    // Single-bit datapath: only the current MSB of each shift register is compared.
    assign m = sa[WIDTH-1] ^ sb[WIDTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            res_valid <= 1'b0;
            diff      <= 1'b0;
            first_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa        <= a;
                        sb        <= b;
                        cnt       <= IDX_W'(WIDTH - 1);
                        diff      <= 1'b0;
                        first_idx <= '0;
                        in_ready  <= 1'b0;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    // The first mismatch wins; later ones are ignored.
                    if (m && !diff) begin
                        diff      <= 1'b1;
                        first_idx <= cnt;
                    end
                    sa  <= sa << 1;
                    sb  <= sb << 1;
                    cnt <= cnt - IDX_W'(1);
                    if (cnt == '0) begin
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef MAG_COMPARE_EN
    // At the first differing bit, whichever operand holds the 1 is the larger one.
    always_ff @(posedge clk) begin
        if (reset) begin
            gt <= 1'b0;
            lt <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            gt <= 1'b0;
            lt <= 1'b0;
        end else if (state == SCAN && m && !diff) begin
            gt <= sa[WIDTH-1];
            lt <= sb[WIDTH-1];
        end
    end
`else
    assign gt = 1'b0;
    assign lt = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_compare.sv
// tb/tb_serial_word_compare.sv - self-checking bench for serial_word_compare.
module tb_serial_word_compare;

    localparam int WIDTH = 6;
    localparam int IDX_W = $clog2(WIDTH);
`ifdef MAG_COMPARE_EN
    localparam bit MAG = 1'b1;
`else
    localparam bit MAG = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic             diff;
    logic [IDX_W-1:0] first_idx;
    logic             gt;
    logic             lt;

    int checks = 0;
    int failures = 0;

    serial_word_compare #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .diff      (diff),
        .first_idx (first_idx),
        .gt        (gt),
        .lt        (lt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             diff;
        int               idx;
        logic             gt;
        logic             lt;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: position of the highest set bit of a^b, plus unsigned ordering.
    task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                         output logic ed, output int ei, output logic eg, output logic el);
        logic [WIDTH-1:0] x;
        x  = ma ^ mb;
        ed = (ma != mb);
        ei = 0;
        for (int i = 0; i < WIDTH; i++)
            if (x[i]) ei = i;
        eg = MAG && (ma > mb);
        el = MAG && (ma < mb);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check({name, "_ready_timeout"}, int'(in_ready), 1);
    endtask

    // Accept one pair, return outputs and the edge count until res_valid is seen by an edge.
    task automatic launch(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          output int edges);
        int n;
        a = va;
        b = vb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        n = 0;
        while (!res_valid && n < 50) begin
            tick();
            n++;
        end
        edges = n + 1;
    endtask

    task automatic release_result(input string name);
        res_ready = 1'b1;
        in_valid  = 1'b1;
        tick();
        res_ready = 1'b0;
        in_valid  = 1'b0;
        check({name, "_rv_drop"}, int'(res_valid), 0);
        check({name, "_in_ready_back"}, int'(in_ready), 1);
    endtask

    task automatic run_check(input string name, input logic [WIDTH-1:0] va,
                             input logic [WIDTH-1:0] vb, input logic ed, input int ei,
                             input logic eg, input logic el, input bit chk_lat);
        int edges;
        wait_ready(name);
        launch(va, vb, edges);
        if (chk_lat) check({name, "_latency"}, edges, WIDTH + 1);
        check({name, "_res_valid"}, int'(res_valid), 1);
        check({name, "_diff"}, int'(diff), int'(ed));
        check({name, "_first_idx"}, int'(first_idx), ei);
        check({name, "_gt"}, int'(gt), int'(eg));
        check({name, "_lt"}, int'(lt), int'(el));
        release_result(name);
    endtask

    vec_t tbl[5];

    initial begin
        logic ed, eg, el;
        int   ei, edges;

        tbl[0] = '{6'b001010, 6'b000100, 1'b1, 3, 1'b1, 1'b0};
        tbl[1] = '{6'b000001, 6'b000001, 1'b0, 0, 1'b0, 1'b0};
        tbl[2] = '{6'b100000, 6'b000001, 1'b1, 5, 1'b1, 1'b0};
        tbl[3] = '{6'b000001, 6'b100000, 1'b1, 5, 1'b0, 1'b1};
        tbl[4] = '{6'b111111, 6'b111110, 1'b1, 0, 1'b1, 1'b0};

        tick();
        tick();
        reset = 1'b0;
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_res_valid", int'(res_valid), 0);
        check("reset_diff", int'(diff), 0);
        check("reset_first_idx", int'(first_idx), 0);
        check("reset_gt", int'(gt), 0);
        check("reset_lt", int'(lt), 0);

        for (int i = 0; i < 5; i++)
            run_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].diff, tbl[i].idx,
                      MAG && tbl[i].gt, MAG && tbl[i].lt, 1'b1);

        // Backpressure: outputs frozen while inputs churn.
        model(6'b001010, 6'b000100, ed, ei, eg, el);
        wait_ready("bp");
        launch(6'b001010, 6'b000100, edges);
        for (int c = 0; c < 10; c++) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            in_valid = 1'($urandom);
            tick();
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_res_valid", int'(res_valid), 1);
            check("bp_diff", int'(diff), int'(ed));
            check("bp_first_idx", int'(first_idx), ei);
            check("bp_gt", int'(gt), int'(eg));
            check("bp_lt", int'(lt), int'(el));
        end
        release_result("bp");

        // Reset asserted during the third SCAN cycle.
        wait_ready("rst");
        a = 6'b100000;
        b = 6'b000001;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_diff", int'(diff), 0);
        check("rst_first_idx", int'(first_idx), 0);
        check("rst_gt", int'(gt), 0);
        check("rst_lt", int'(lt), 0);
        for (int c = 0; c < WIDTH + 2; c++) begin
            tick();
            check("rst_no_result", int'(res_valid), 0);
        end
        run_check("post_rst", 6'b000010, 6'b000010, 1'b0, 0, 1'b0, 1'b0, 1'b1);

        // Randomized pairs against the reference model.
        for (int r = 0; r < 40; r++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = WIDTH'($urandom);
            case (r % 4)
                0:       rb = ra;
                1:       rb = ra ^ (WIDTH'(1) << $urandom_range(WIDTH - 1, 0));
                default: rb = WIDTH'($urandom);
            endcase
            model(ra, rb, ed, ei, eg, el);
            run_check($sformatf("rnd%0d", r), ra, rb, ed, ei, eg, el, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
